spmm_csr_feeder: RTL and testbench
==================================

Name: spmm_csr_feeder

Overview:
- Upstream stage of the SpMM processing element.
- Walks a CSR-encoded feature matrix row by row and reads per-row nonzero counts and (col_idx, value) pairs from BRAM.
- Streams one nonzero per cycle to the PE over a valid/ready interface, with row_length held alongside every element.
- Absorbs the BRAM's 1-cycle read latency and downstream backpressure with a 2-entry output buffer.

Parameters:
- DATA_WIDTH, 8, signed nonzero value width
- COL_IDX_WIDTH, 11, column index width (weight row address)
- ROW_LEN_WIDTH, 5, per-row nonzero count width
- NUM_ROWS, 2708, rows to walk per start
- ROW_ADDR_W, 12, $clog2(NUM_ROWS)
- NZ_ADDR_W, 16, nonzero BRAM address width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  begin a pass; ignored while busy_o=1
- busy_o  out  1  pass in progress
- done_o  out  1  single-cycle pulse at end of pass
- rowlen_addr_o  out  ROW_ADDR_W  row-length BRAM address
- rowlen_dout_i  in  ROW_LEN_WIDTH  row-length BRAM data, 1-cycle latency
- nz_addr_o  out  NZ_ADDR_W  nonzero BRAM address
- nz_rd_en_o  out  1  nonzero BRAM read enable
- nz_col_idx_i  in  COL_IDX_WIDTH  BRAM data, 1-cycle latency
- nz_value_i  in  DATA_WIDTH  BRAM data, 1-cycle latency
- nz_valid_o  out  1  output element valid
- nz_ready_i  in  1  downstream accepts
- col_idx_o  out  COL_IDX_WIDTH  element column
- value_o  out  DATA_WIDTH  element value
- row_length_o  out  ROW_LEN_WIDTH  nonzero count of the element's row
- first_o  out  1  first element of row; nz_valid_o&&first_o drives PE pe_valid
- last_o  out  1  last element of row
- row_idx_o  out  ROW_ADDR_W  row of element

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE, buffer is empty, counters are 0.
- FSM states:
  - IDLE:
    - start_i=1: row_cnt=0, nz_addr=0, busy_o=1, go to LEN_REQ.
  - LEN_REQ:
    - Drive rowlen_addr_o=row_cnt, go to LEN_CAP.
  - LEN_CAP:
    - Latch rowlen_dout_i into cur_len and clear elem_cnt.
    - If cur_len==0: the row is skipped and emits nothing. If row_cnt==NUM_ROWS-1 go to DRAIN, else row_cnt+1 and go to LEN_REQ.
    - Otherwise go to STREAM.
  - STREAM:
    - Read-issue condition (occ + inflight − pop) < 2, where pop = nz_valid_o&&nz_ready_i.
    - On issue: nz_rd_en_o=1 and nz_addr_o=nz_addr.
    - Sideband is tagged into the in-flight slot: first = (elem_cnt==0), last = (elem_cnt==cur_len−1), row_length=cur_len, row_idx=row_cnt.
    - After issue: nz_addr+1 and elem_cnt+1.
    - On issuing the last element: if last row go to DRAIN, else row_cnt+1 and go to LEN_REQ. Buffered entries carry their own row_length, so they keep flowing during LEN_REQ/LEN_CAP.
  - DRAIN:
    - When buffer empty and nothing in flight: done_o=1 for one cycle, busy_o=0, go to IDLE.
- Buffer: 2-entry FIFO, written the cycle after issue with BRAM data plus tagged sideband.
  - Outputs are driven from the head entry.
  - Push and pop may occur in the same cycle.
  - Never overflows, by the issue rule.
  - Output fields are stable while nz_valid_o=1 && nz_ready_i=0.
- Throughput: 1 element/cycle while nz_ready_i=1 within a row. Each row boundary costs 2 issue-bubble cycles (LEN_REQ, LEN_CAP).
- Latency: start_i to first nz_valid_o is 4 cycles (LEN_REQ, LEN_CAP, issue, buffer).
- nz_addr wraps modulo 2^NZ_ADDR_W. The total nonzero count must be below 2^NZ_ADDR_W; this is not checked.
- An all-empty matrix yields done_o with zero elements emitted.
- rst_n low mid-pass: abort immediately. Buffer is flushed, done_o is not pulsed, state returns to IDLE.

Optional Feature:
- Macro: SPMM_FEEDER_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt_o (32 bits).
  - Counts cycles with nz_valid_o=1 && nz_ready_i=0.
  - Also adds output elem_cnt_o (NZ_ADDR_W bits), counting accepted elements.
  - Both clear on start accept and hold after done.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- params_pkg: DATA_WIDTH, COL_IDX_WIDTH, ROW_LEN_WIDTH, NUM_ROWS, ROW_ADDR_W, NZ_ADDR_W.
- params_pkg also holds feeder_state_t enum {IDLE, LEN_REQ, LEN_CAP, STREAM, DRAIN} and the nz_elem_t packed struct {col_idx, value, row_length, first, last, row_idx}.
- One sub-module: spmm_feeder_fifo2. It is the 2-entry nz_elem_t FIFO with push, pop, occ, head.

Test Plan:
- Row lengths {3,1,2}, nonzeros (col,val)=(5,2),(7,−3),(9,4),(0,1),(2,−1),(4,5), ready always 1:
  - 6 elements are emitted back-to-back within each row, each row followed by 2 bubbles.
  - first/last: row0 (1,0)(0,0)(0,1); row1 (1,1); row2 (1,0)(0,1).
  - row_length 3,3,3,1,2,2; done_o 1 cycle after the last accept.
- Same data with ready toggling 1,0,0,1,…: no drop or duplication, fields stable during stall, nz_rd_en_o never raised with occ+inflight=2.
- Row lengths {0,2,0}: only row1's 2 elements are emitted with row_idx_o=1, and done_o pulses.
- All rows length 0 (NUM_ROWS=4): zero nz_valid_o, done_o pulses after 8 LEN cycles, then one DRAIN cycle.
- rst_n asserted mid-row: the next cycle all outputs are 0 and state is IDLE; a restart with start_i re-emits from nz_addr=0.
- start_i held high during a pass and at done: no restart mid-pass; a new pass begins only on start_i sampled in IDLE.

Source files
------------

// File: rtl/spmm_csr_feeder_pkg.sv
// Shared widths, FSM state encoding and the buffered element record for the SpMM CSR feeder.
// The optional performance counters are enabled with SPMM_FEEDER_PERF_CNT_EN.
package spmm_csr_feeder_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int COL_IDX_WIDTH = 11;
    localparam int ROW_LEN_WIDTH = 5;
    localparam int NUM_ROWS      = 2708;
    localparam int ROW_ADDR_W    = $clog2(NUM_ROWS);
    localparam int NZ_ADDR_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_REQ,
        LEN_CAP,
        STREAM,
        DRAIN
    } feeder_state_t;

    // One nonzero plus the row sideband it travels with through the output buffer.
    typedef struct packed {
        logic [COL_IDX_WIDTH-1:0] col_idx;
        logic [DATA_WIDTH-1:0]    value;
        logic [ROW_LEN_WIDTH-1:0] row_length;
        logic                     first;
        logic                     last;
        logic [ROW_ADDR_W-1:0]    row_idx;
    } nz_elem_t;

endpackage

// File: rtl/spmm_csr_feeder_fifo2.sv
// Two-entry element FIFO between the BRAM read return and the PE handshake.
// Head is presented combinationally; push and pop may coincide.
module spmm_feeder_fifo2
    import spmm_csr_feeder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  nz_elem_t   push_data_i,
    input  logic       pop_i,
    output logic [1:0] occ_o,
    output nz_elem_t   head_o
);

    nz_elem_t   mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] occ_q;

    // Storage is cleared on reset so an aborted pass leaves no stale element on the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/spmm_csr_feeder.sv
// CSR row walker: fetches row lengths and nonzeros from BRAM and streams one element per cycle to the PE.
// Defining SPMM_FEEDER_PERF_CNT_EN adds stall and accepted-element counters.
module spmm_csr_feeder
    import spmm_csr_feeder_pkg::*;
#(
    parameter int NUM_ROWS = spmm_csr_feeder_pkg::NUM_ROWS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [ROW_ADDR_W-1:0]    rowlen_addr_o,
    input  logic [ROW_LEN_WIDTH-1:0] rowlen_dout_i,
    output logic [NZ_ADDR_W-1:0]     nz_addr_o,
    output logic                     nz_rd_en_o,
    input  logic [COL_IDX_WIDTH-1:0] nz_col_idx_i,
    input  logic [DATA_WIDTH-1:0]    nz_value_i,
    output logic                     nz_valid_o,
    input  logic                     nz_ready_i,
    output logic [COL_IDX_WIDTH-1:0] col_idx_o,
    output logic [DATA_WIDTH-1:0]    value_o,
    output logic [ROW_LEN_WIDTH-1:0] row_length_o,
    output logic                     first_o,
    output logic                     last_o,
    output logic [ROW_ADDR_W-1:0]    row_idx_o
`ifdef SPMM_FEEDER_PERF_CNT_EN
    ,
    output logic [31:0]              stall_cnt_o,
    output logic [NZ_ADDR_W-1:0]     elem_cnt_o
`endif
);

    feeder_state_t            state_q;
    logic [ROW_ADDR_W-1:0]    row_cnt_q;
    logic [NZ_ADDR_W-1:0]     nz_addr_q;
    logic [ROW_LEN_WIDTH-1:0] cur_len_q;
    logic [ROW_LEN_WIDTH-1:0] elem_cnt_q;
    logic                     busy_q;
    logic                     done_q;

    logic                     inflight_q;
    logic                     tag_first_q;
    logic                     tag_last_q;
    logic [ROW_LEN_WIDTH-1:0] tag_len_q;
    logic [ROW_ADDR_W-1:0]    tag_row_q;

    logic [1:0] occ;
    logic [1:0] fill;
    nz_elem_t   head;
    nz_elem_t   push_data;
    logic       head_valid;
    logic       pop;
    logic       issue;
    logic       issue_last;
    logic       last_row;
    logic       drain_empty;

    // A read may issue only if the buffer still has room once this cycle's pop is counted.
    always_comb begin
        head_valid  = (occ != 2'd0);
        pop         = head_valid && nz_ready_i;
        fill        = occ + {1'b0, inflight_q};
        last_row    = (row_cnt_q == ROW_ADDR_W'(NUM_ROWS - 1));
        issue_last  = (elem_cnt_q == (cur_len_q - ROW_LEN_WIDTH'(1)));
        issue       = (state_q == STREAM) && ((fill < 2'd2) || ((fill == 2'd2) && pop));
        drain_empty = !inflight_q && ((occ == 2'd0) || ((occ == 2'd1) && pop));

        push_data            = '0;
        push_data.col_idx    = nz_col_idx_i;
        push_data.value      = nz_value_i;
        push_data.row_length = tag_len_q;
        push_data.first      = tag_first_q;
        push_data.last       = tag_last_q;
        push_data.row_idx    = tag_row_q;
    end

    // Row lengths are consumed straight from BRAM in LEN_CAP so a zero-length row never enters STREAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            nz_addr_q   <= '0;
            cur_len_q   <= '0;
            elem_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
            tag_first_q <= 1'b0;
            tag_last_q  <= 1'b0;
            tag_len_q   <= '0;
            tag_row_q   <= '0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (issue) begin
                tag_first_q <= (elem_cnt_q == '0);
                tag_last_q  <= issue_last;
                tag_len_q   <= cur_len_q;
                tag_row_q   <= row_cnt_q;
            end

            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        row_cnt_q <= '0;
                        nz_addr_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= LEN_REQ;
                    end
                end
                LEN_REQ: begin
                    state_q <= LEN_CAP;
                end
                LEN_CAP: begin
                    cur_len_q  <= rowlen_dout_i;
                    elem_cnt_q <= '0;
                    if (rowlen_dout_i == '0) begin
                        if (last_row) begin
                            state_q <= DRAIN;
                        end else begin
                            row_cnt_q <= row_cnt_q + ROW_ADDR_W'(1);
                            state_q   <= LEN_REQ;
                        end
                    end else begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (issue) begin
                        nz_addr_q  <= nz_addr_q + NZ_ADDR_W'(1);
                        elem_cnt_q <= elem_cnt_q + ROW_LEN_WIDTH'(1);
                        if (issue_last) begin
                            if (last_row) begin
                                state_q <= DRAIN;
                            end else begin
                                row_cnt_q <= row_cnt_q + ROW_ADDR_W'(1);
                                state_q   <= LEN_REQ;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    spmm_feeder_fifo2 u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (head)
    );

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign rowlen_addr_o = row_cnt_q;
    assign nz_addr_o     = nz_addr_q;
    assign nz_rd_en_o    = issue;
    assign nz_valid_o    = head_valid;
    assign col_idx_o     = head.col_idx;
    assign value_o       = head.value;
    assign row_length_o  = head.row_length;
    assign first_o       = head.first;
    assign last_o        = head.last;
    assign row_idx_o     = head.row_idx;

`ifdef SPMM_FEEDER_PERF_CNT_EN
    logic [31:0]          stall_cnt_q;
    logic [NZ_ADDR_W-1:0] perf_elem_cnt_q;

    // Counters restart on each accepted start and simply stop moving once the buffer has drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q     <= '0;
            perf_elem_cnt_q <= '0;
        end else if ((state_q == IDLE) && start_i) begin
            stall_cnt_q     <= '0;
            perf_elem_cnt_q <= '0;
        end else begin
            if (head_valid && !nz_ready_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (pop) begin
                perf_elem_cnt_q <= perf_elem_cnt_q + NZ_ADDR_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign elem_cnt_o  = perf_elem_cnt_q;
`endif

endmodule

// File: tb/tb_spmm_csr_feeder.sv
// Scoreboard bench for spmm_csr_feeder: BRAM models feed the DUT, a row model predicts every element.
// Covers reset, back-to-back streaming, backpressure, empty rows, mid-pass abort and held start.
module tb_spmm_csr_feeder;
    import spmm_csr_feeder_pkg::*;

    localparam int TB_ROWS = 3;

    logic                     clk = 1'b0;
    logic                     rstN;
    logic                     startIn;
    logic                     busyOut;
    logic                     doneOut;
    logic [ROW_ADDR_W-1:0]    rowLenAddr;
    logic [ROW_LEN_WIDTH-1:0] rowLenDout = '0;
    logic [NZ_ADDR_W-1:0]     nzAddr;
    logic                     nzRdEn;
    logic [COL_IDX_WIDTH-1:0] nzColIdx = '0;
    logic [DATA_WIDTH-1:0]    nzValue = '0;
    logic                     nzValid;
    logic                     nzReady;
    logic [COL_IDX_WIDTH-1:0] colIdxOut;
    logic [DATA_WIDTH-1:0]    valueOut;
    logic [ROW_LEN_WIDTH-1:0] rowLengthOut;
    logic                     firstOut;
    logic                     lastOut;
    logic [ROW_ADDR_W-1:0]    rowIdxOut;
`ifdef SPMM_FEEDER_PERF_CNT_EN
    logic [31:0]              stallCnt;
    logic [NZ_ADDR_W-1:0]     perfElemCnt;
`endif

    logic [ROW_LEN_WIDTH-1:0] rowLenMem [4];
    logic [COL_IDX_WIDTH-1:0] colMem [16];
    logic [DATA_WIDTH-1:0]    valMem [16];

    logic [37:0] expQ [$];
    int          expCyc [$];
    int          acceptCyc [$];
    int          expDoneRel;
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          startCyc = 0;
    int          acceptCount = 0;
    int          doneCount = 0;
    bit          readyMode = 1'b0;
    int          readyPhase = 0;

    spmm_csr_feeder #(.NUM_ROWS(TB_ROWS)) dut (
        .clk           (clk),
        .rst_n         (rstN),
        .start_i       (startIn),
        .busy_o        (busyOut),
        .done_o        (doneOut),
        .rowlen_addr_o (rowLenAddr),
        .rowlen_dout_i (rowLenDout),
        .nz_addr_o     (nzAddr),
        .nz_rd_en_o    (nzRdEn),
        .nz_col_idx_i  (nzColIdx),
        .nz_value_i    (nzValue),
        .nz_valid_o    (nzValid),
        .nz_ready_i    (nzReady),
        .col_idx_o     (colIdxOut),
        .value_o       (valueOut),
        .row_length_o  (rowLengthOut),
        .first_o       (firstOut),
        .last_o        (lastOut),
        .row_idx_o     (rowIdxOut)
`ifdef SPMM_FEEDER_PERF_CNT_EN
        ,
        .stall_cnt_o   (stallCnt),
        .elem_cnt_o    (perfElemCnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Synchronous-read BRAM models with one cycle of latency
    always @(posedge clk) begin
        rowLenDout <= rowLenMem[rowLenAddr[1:0]];
        if (nzRdEn) begin
            nzColIdx <= colMem[nzAddr[3:0]];
            nzValue  <= valMem[nzAddr[3:0]];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, observed, expected, cycle);
        end
    endtask

    function automatic logic [37:0] packElem(input logic [COL_IDX_WIDTH-1:0] col, input logic [DATA_WIDTH-1:0] val,
                                             input logic [ROW_LEN_WIDTH-1:0] len, input logic first, input logic last,
                                             input logic [ROW_ADDR_W-1:0] row);
        return {col, val, len, first, last, row};
    endfunction

    // Row model: predicts elements, their accept cycles with ready held high, and the done cycle
    task automatic modelPush();
        int addr = 0;
        int c = 1;
        int lastAcc = 0;
        expCyc.delete();
        for (int r = 0; r < TB_ROWS; r++) begin
            int len;
            len = int'(rowLenMem[r]);
            c += 2;
            for (int e = 0; e < len; e++) begin
                expQ.push_back(packElem(colMem[addr], valMem[addr], rowLenMem[r], e == 0, e == len - 1, ROW_ADDR_W'(r)));
                expCyc.push_back(c + 1);
                lastAcc = c + 1;
                c++;
                addr++;
            end
        end
        expDoneRel = (lastAcc + 1 > c) ? lastAcc + 1 : c;
    endtask

    task automatic applyStimulus(input int l0, input int l1, input int l2, input bit holdStart);
        rowLenMem[0] = ROW_LEN_WIDTH'(l0);
        rowLenMem[1] = ROW_LEN_WIDTH'(l1);
        rowLenMem[2] = ROW_LEN_WIDTH'(l2);
        rowLenMem[3] = '0;
        modelPush();
        acceptCyc.delete();
        @(posedge clk);
        #1 startIn = 1'b1;
        @(posedge clk);
        #1 startIn = holdStart;
        startCyc = cycle;
    endtask

    task automatic waitDone(input int budget, output int rel);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (doneOut) seen = 1'b1;
        end
        if (!seen) checkOutput("doneTimeout", 64'd0, 64'd1);
        else checkOutput("busyAtDone", busyOut, 0);
        rel = cycle - startCyc;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Ctrl"}, {busyOut, doneOut, rowLenAddr, nzAddr, nzRdEn}, 0);
        checkOutput({tag, "Data"}, {nzValid, colIdxOut, valueOut, rowLengthOut, firstOut, lastOut, rowIdxOut}, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (readyMode) begin
                nzReady = (readyPhase == 0) || (readyPhase == 3);
                readyPhase = (readyPhase + 1) % 4;
            end else begin
                nzReady = 1'b1;
            end
        end
    end

    // Monitor: scoreboard pops, stall stability, buffer occupancy model and issue-rule check
    initial begin
        int          tbOcc = 0;
        int          tbInflight = 0;
        bit          stallHeld = 1'b0;
        bit          prevDone = 1'b0;
        int          popNow;
        logic [37:0] obs;
        logic [37:0] held = '0;
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                tbOcc = 0;
                tbInflight = 0;
                stallHeld = 1'b0;
                prevDone = 1'b0;
            end else begin
                obs = {colIdxOut, valueOut, rowLengthOut, firstOut, lastOut, rowIdxOut};
                popNow = (nzValid && nzReady) ? 1 : 0;
                checkOutput("validOcc", nzValid, tbOcc != 0);
                if (nzRdEn) checkOutput("issueRule", (tbOcc + tbInflight - popNow) < 2, 1);
                if (stallHeld) checkOutput("stallHold", {nzValid, obs}, {1'b1, held});
                stallHeld = nzValid && !nzReady;
                held = obs;
                if (popNow != 0) begin
                    if (expQ.size() == 0) begin
                        checkOutput("extraElem", obs, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("elem", obs, e);
                    end
                    acceptCyc.push_back(cycle - startCyc);
                    acceptCount++;
                end
                if (doneOut) begin
                    doneCount++;
                    if (prevDone) checkOutput("donePulse", 64'd2, 64'd1);
                end
                prevDone = doneOut;
                tbOcc = tbOcc + tbInflight - popNow;
                tbInflight = nzRdEn ? 1 : 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cols [6] = '{5, 7, 9, 0, 2, 4};
        int vals [6] = '{2, -3, 4, 1, -1, 5};
        int rel;
        int base;
        int savedDone;
        bit reached;

        rstN = 1'b0;
        startIn = 1'b0;
        nzReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            colMem[i] = (i < 6) ? COL_IDX_WIDTH'(cols[i]) : '0;
            valMem[i] = (i < 6) ? DATA_WIDTH'(vals[i]) : '0;
        end
        for (int i = 0; i < 4; i++) rowLenMem[i] = '0;

        repeat (3) @(posedge clk);
        #1 checkAllZero("reset");
        rstN = 1'b1;

        $display("[TB] rows {3,1,2} with ready held high");
        base = acceptCount;
        applyStimulus(3, 1, 2, 1'b0);
        waitDone(200, rel);
        checkOutput("doneCycle", rel, expDoneRel);
        checkOutput("acceptNum", acceptCyc.size(), expCyc.size());
        for (int i = 0; i < expCyc.size(); i++) begin
            checkOutput("acceptCycle", (i < acceptCyc.size()) ? acceptCyc[i] : -1, expCyc[i]);
        end
        checkOutput("sbEmpty1", expQ.size(), 0);

        $display("[TB] rows {3,1,2} with ready toggling");
        readyMode = 1'b1;
        readyPhase = 0;
        base = acceptCount;
        applyStimulus(3, 1, 2, 1'b0);
        waitDone(400, rel);
        readyMode = 1'b0;
        checkOutput("stallCount", acceptCount - base, 6);
        checkOutput("sbEmpty2", expQ.size(), 0);

        $display("[TB] rows {0,2,0}");
        base = acceptCount;
        applyStimulus(0, 2, 0, 1'b0);
        waitDone(200, rel);
        checkOutput("skipDone", rel, expDoneRel);
        checkOutput("skipCount", acceptCount - base, 2);
        checkOutput("sbEmpty3", expQ.size(), 0);

        $display("[TB] all rows empty");
        base = acceptCount;
        applyStimulus(0, 0, 0, 1'b0);
        waitDone(200, rel);
        checkOutput("emptyDone", rel, 2 * TB_ROWS + 1);
        checkOutput("emptyCount", acceptCount - base, 0);

        $display("[TB] reset in the middle of row 0");
        base = acceptCount;
        applyStimulus(3, 1, 2, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(posedge clk);
            if (acceptCount - base >= 2) reached = 1'b1;
        end
        if (!reached) checkOutput("acceptTimeout", 64'd0, 64'd1);
        savedDone = doneCount;
        #1 rstN = 1'b0;
        expQ.delete();
        @(posedge clk);
        #1 checkAllZero("abort");
        rstN = 1'b1;
        repeat (3) @(posedge clk);
        checkOutput("abortNoDone", doneCount, savedDone);
        base = acceptCount;
        applyStimulus(3, 1, 2, 1'b0);
        waitDone(200, rel);
        checkOutput("restartCount", acceptCount - base, 6);
        checkOutput("sbEmpty4", expQ.size(), 0);

        $display("[TB] start held high across a pass");
        base = acceptCount;
        applyStimulus(3, 1, 2, 1'b1);
        waitDone(200, rel);
        checkOutput("heldPassCount", acceptCount - base, 6);
        modelPush();
        @(posedge clk);
        #1 startIn = 1'b0;
        startCyc = cycle;
        checkOutput("restartBusy", busyOut, 1);
        waitDone(200, rel);
        checkOutput("heldTotal", acceptCount - base, 12);
        checkOutput("sbEmpty5", expQ.size(), 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
